// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encoding,
// instruction classes, opcode/func fields and datapath select encodings.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_DCD   = 3'd1,
        ST_EXE   = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_HALT  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP   = 4'd0,
        CL_J     = 4'd1,
        CL_JAL   = 4'd2,
        CL_JR    = 4'd3,
        CL_RTYPE = 4'd4,
        CL_IMM   = 4'd5,
        CL_LW    = 4'd6,
        CL_SW    = 4'd7,
        CL_BEQ   = 4'd8,
        CL_ILL   = 4'd9
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_J    = 2'd2;
    localparam logic [1:0] NPC_RS   = 2'd3;

    localparam logic [1:0] SRC_RT   = 2'd0;
    localparam logic [1:0] SRC_SEXT = 2'd1;
    localparam logic [1:0] SRC_ZEXT = 2'd2;
    localparam logic [1:0] SRC_LUI  = 2'd3;

    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_RA   = 2'd2;

    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_DM    = 2'd1;
    localparam logic [1:0] WD_PC    = 2'd2;

    function automatic logic [5:0] op_of(input logic [31:0] ins);
        return ins[31:26];
    endfunction

    function automatic logic [5:0] fn_of(input logic [31:0] ins);
        return ins[5:0];
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: classifies the IR contents and supplies
// the datapath selects that the FSM later gates per state.
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] instr,
    output iclass_t     cls,
    output logic [3:0]  alu_op,
    output logic [1:0]  alu_src,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg
);

    logic [5:0] op_s;
    logic [5:0] fn_s;

    assign op_s = op_of(instr);
    assign fn_s = fn_of(instr);

    // Opcode/func to class and select mapping
    always_comb begin
        cls        = CL_ILL;
        alu_op     = ALU_ADD;
        alu_src    = SRC_RT;
        reg_dst    = DST_RT;
        mem_to_reg = WD_ALU;
        case (op_s)
            OP_RTYPE: begin
                if (instr == 32'h0000_0000) begin
                    cls = CL_NOP;
                end else begin
                    case (fn_s)
                        FN_ADDU: begin
                            cls     = CL_RTYPE;
                            reg_dst = DST_RD;
                        end
                        FN_SUBU: begin
                            cls     = CL_RTYPE;
                            alu_op  = ALU_SUB;
                            reg_dst = DST_RD;
                        end
                        FN_JR:   cls = CL_JR;
                        default: cls = CL_ILL;
                    endcase
                end
            end
            OP_ORI: begin
                cls     = CL_IMM;
                alu_op  = ALU_OR;
                alu_src = SRC_ZEXT;
            end
            OP_LUI: begin
                cls     = CL_IMM;
                alu_src = SRC_LUI;
            end
            OP_LW: begin
                cls        = CL_LW;
                alu_src    = SRC_SEXT;
                mem_to_reg = WD_DM;
            end
            OP_SW: begin
                cls     = CL_SW;
                alu_src = SRC_SEXT;
            end
            OP_BEQ: begin
                cls    = CL_BEQ;
                alu_op = ALU_SUB;
            end
            OP_J:    cls = CL_J;
            OP_JAL: begin
                cls        = CL_JAL;
                reg_dst    = DST_RA;
                mem_to_reg = WD_PC;
            end
            default: cls = CL_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// with ready handshakes, a retired counter and a memory-wait watchdog.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic [1:0]       npc_sel,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       alu_src,
    output logic [3:0]       alu_op,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             illegal,
    output logic             err,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_o
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    iclass_t    cls_s;
    logic [3:0] dec_alu_op_s;
    logic [1:0] dec_alu_src_s;
    logic [1:0] dec_reg_dst_s;
    logic [1:0] dec_mem_to_reg_s;

    logic       retire_s;
    logic       wd_hit_s;
    logic       pc_wr_s, ir_wr_s, reg_write_s, dmem_req_s, dmem_we_s, illegal_s;
    logic [1:0] npc_sel_s, reg_dst_s, mem_to_reg_s, alu_src_s;
    logic [3:0] alu_op_s;

    mc_decode u_decode (
        .instr      (instr),
        .cls        (cls_s),
        .alu_op     (dec_alu_op_s),
        .alu_src    (dec_alu_src_s),
        .reg_dst    (dec_reg_dst_s),
        .mem_to_reg (dec_mem_to_reg_s)
    );

    // This wait cycle is the TIMEOUT-th consecutive one; TIMEOUT of 0 never fires
    assign wd_hit_s = (TIMEOUT != 0) &&
                      ({{(32-WD_W){1'b0}}, wd_q} == 32'(TIMEOUT - 1));

    // Next-state, strobe and watchdog decode
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        wd_d         = '0;
        retire_s     = 1'b0;
        pc_wr_s      = 1'b0;
        ir_wr_s      = 1'b0;
        npc_sel_s    = NPC_PC4;
        reg_write_s  = 1'b0;
        reg_dst_s    = DST_RT;
        mem_to_reg_s = WD_ALU;
        alu_src_s    = SRC_RT;
        alu_op_s     = ALU_ADD;
        dmem_req_s   = 1'b0;
        dmem_we_s    = 1'b0;
        illegal_s    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    ir_wr_s   = 1'b1;
                    pc_wr_s   = 1'b1;
                    npc_sel_s = NPC_PC4;
                    state_d   = ST_DCD;
                end else if (wd_hit_s) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_DCD: begin
                case (cls_s)
                    CL_NOP: begin
                        retire_s = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CL_J: begin
                        pc_wr_s   = 1'b1;
                        npc_sel_s = NPC_J;
                        retire_s  = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    CL_JAL: begin
                        pc_wr_s      = 1'b1;
                        npc_sel_s    = NPC_J;
                        reg_write_s  = 1'b1;
                        reg_dst_s    = dec_reg_dst_s;
                        mem_to_reg_s = dec_mem_to_reg_s;
                        retire_s     = 1'b1;
                        state_d      = ST_FETCH;
                    end
                    CL_JR: begin
                        pc_wr_s   = 1'b1;
                        npc_sel_s = NPC_RS;
                        retire_s  = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    CL_ILL: begin
                        illegal_s = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    default: state_d = ST_EXE;
                endcase
            end
            ST_EXE: begin
                alu_op_s  = dec_alu_op_s;
                alu_src_s = dec_alu_src_s;
                case (cls_s)
                    CL_BEQ: begin
                        if (alu_zero) begin
                            pc_wr_s   = 1'b1;
                            npc_sel_s = NPC_BR;
                        end else begin
                            pc_wr_s   = 1'b0;
                        end
                        retire_s = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CL_LW, CL_SW: state_d = ST_MEM;
                    default:      state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                alu_op_s   = dec_alu_op_s;
                alu_src_s  = dec_alu_src_s;
                dmem_req_s = 1'b1;
                dmem_we_s  = (cls_s == CL_SW);
                if (dmem_ready) begin
                    if (cls_s == CL_SW) begin
                        retire_s = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d  = ST_WB;
                    end
                end else if (wd_hit_s) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_WB: begin
                alu_op_s     = dec_alu_op_s;
                alu_src_s    = dec_alu_src_s;
                reg_write_s  = 1'b1;
                reg_dst_s    = dec_reg_dst_s;
                mem_to_reg_s = dec_mem_to_reg_s;
                retire_s     = 1'b1;
                state_d      = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
        retired_d = retired_q + CNT_W'(retire_s);
    end

    // State, watchdog, error flag and retired counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            err_q     <= 1'b0;
            wd_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            wd_q      <= wd_d;
            retired_q <= retired_d;
        end
    end

    // Strobes are silenced for as long as reset is held low
    assign pc_wr      = reset & pc_wr_s;
    assign ir_wr      = reset & ir_wr_s;
    assign reg_write  = reset & reg_write_s;
    assign dmem_req   = reset & dmem_req_s;
    assign dmem_we    = reset & dmem_we_s;
    assign illegal    = reset & illegal_s;
    assign npc_sel    = reset ? npc_sel_s    : 2'd0;
    assign reg_dst    = reset ? reg_dst_s    : 2'd0;
    assign mem_to_reg = reset ? mem_to_reg_s : 2'd0;
    assign alu_src    = reset ? alu_src_s    : 2'd0;
    assign alu_op     = reset ? alu_op_s     : 4'd0;
    assign err        = err_q;
    assign retired    = retired_q;
    assign state_o    = state_q;

endmodule
